// File: rtl/ldm_stm_sequencer.sv
// Load/store-multiple block transfer sequencer.
// Walks a 16-bit register bitmap lowest-index first, issuing one memory beat per set bit at
// ascending word addresses. The start address and final base value depend on the addressing
// mode (IA/IB/DA/DB). An optional base writeback strobe follows the last beat.
// Ports:
//   clk_in, reset_n_in             clock, asynchronous active-low reset
//   start_in + request fields      reg_list_in, base_addr_in, mode_in, load_in, writeback_in
//   mem_ack_in                     memory accepts the current beat (only honoured in XFER)
//   mem_req_out/addr/we            memory beat request
//   reg_addr_out, reg_we_out       register-file index and LDM write strobe
//   wb_en_out, wb_data_out         base writeback strobe and value
//   busy_out, done_out             transfer in progress, one-cycle completion pulse
module ldm_stm_sequencer (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        start_in,
  input  logic [15:0] reg_list_in,
  input  logic [31:0] base_addr_in,
  input  logic [1:0]  mode_in,
  input  logic        load_in,
  input  logic        writeback_in,
  input  logic        mem_ack_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  output logic        mem_we_out,
  output logic [3:0]  reg_addr_out,
  output logic        reg_we_out,
  output logic        wb_en_out,
  output logic [31:0] wb_data_out,
  output logic        busy_out,
  output logic        done_out
);

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StWb, StDone} state_e;

  state_e      r_state;
  logic [15:0] r_list;
  logic [31:0] r_base;
  logic [1:0]  r_mode;
  logic        r_load;
  logic        r_wb;
  logic [31:0] r_addr;
  logic [31:0] r_final;

  logic [4:0]  w_count;
  logic [31:0] w_span;
  logic [31:0] w_start;
  logic [31:0] w_final;
  logic [3:0]  w_reg_idx;
  logic [15:0] w_list_next;
  logic        w_in_xfer;

  always_comb begin
    w_count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      w_count = w_count + {4'd0, r_list[i]};
    end
  end

  assign w_span = {25'd0, w_count, 2'b00};

  // Every mode transfers at ascending addresses, so the decrementing modes start low.
  always_comb begin
    unique case (r_mode)
      2'b00:   w_start = r_base;
      2'b01:   w_start = r_base + 32'd4;
      2'b10:   w_start = r_base - w_span + 32'd4;
      default: w_start = r_base - w_span;
    endcase
  end

  assign w_final = r_mode[1] ? (r_base - w_span) : (r_base + w_span);

  // Lowest set bit wins: scan downwards so the last hit is the lowest index.
  always_comb begin
    w_reg_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (r_list[i]) w_reg_idx = 4'(i);
    end
  end

  assign w_list_next = r_list & (r_list - 16'd1);
  assign w_in_xfer   = (r_state == StXfer);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= StIdle;
      r_list  <= 16'd0;
      r_base  <= 32'd0;
      r_mode  <= 2'd0;
      r_load  <= 1'b0;
      r_wb    <= 1'b0;
      r_addr  <= 32'd0;
      r_final <= 32'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start_in) begin
            r_list  <= reg_list_in;
            r_base  <= base_addr_in;
            r_mode  <= mode_in;
            r_load  <= load_in;
            r_wb    <= writeback_in;
            r_state <= StSetup;
          end
        end
        StSetup: begin
          r_addr  <= w_start;
          r_final <= w_final;
          r_state <= (w_count == 5'd0) ? StDone : StXfer;
        end
        StXfer: begin
          if (mem_ack_in) begin
            r_list <= w_list_next;
            r_addr <= r_addr + 32'd4;
            if (w_list_next == 16'd0) r_state <= r_wb ? StWb : StDone;
          end
        end
        StWb:    r_state <= StDone;
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign mem_req_out  = w_in_xfer;
  assign mem_addr_out = w_in_xfer ? r_addr : 32'd0;
  assign mem_we_out   = w_in_xfer & ~r_load;
  assign reg_addr_out = w_in_xfer ? w_reg_idx : 4'd0;
  // Combinational so the register write lands in the same cycle the ack is accepted.
  assign reg_we_out   = w_in_xfer & mem_ack_in & r_load;
  assign wb_en_out    = (r_state == StWb);
  assign wb_data_out  = (r_state == StWb) ? r_final : 32'd0;
  assign busy_out     = (r_state != StIdle);
  assign done_out     = (r_state == StDone);

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer. Inputs are driven and outputs sampled on the falling
// edge. Cycle 0 is the cycle start_in is presented; cycle k is the k-th cycle after that.
module tb_ldm_stm_sequencer;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        start_in;
  logic [15:0] reg_list_in;
  logic [31:0] base_addr_in;
  logic [1:0]  mode_in;
  logic        load_in;
  logic        writeback_in;
  logic        mem_ack_in;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_we_out;
  logic [3:0]  reg_addr_out;
  logic        reg_we_out;
  logic        wb_en_out;
  logic [31:0] wb_data_out;
  logic        busy_out;
  logic        done_out;

  int n_cmp = 0;
  int n_mis = 0;

  logic [3:0]  e_reg  [16];
  logic [31:0] e_addr [16];

  always #5 clk_in = ~clk_in;

  ldm_stm_sequencer dut (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .start_in     (start_in),
    .reg_list_in  (reg_list_in),
    .base_addr_in (base_addr_in),
    .mode_in      (mode_in),
    .load_in      (load_in),
    .writeback_in (writeback_in),
    .mem_ack_in   (mem_ack_in),
    .mem_req_out  (mem_req_out),
    .mem_addr_out (mem_addr_out),
    .mem_we_out   (mem_we_out),
    .reg_addr_out (reg_addr_out),
    .reg_we_out   (reg_we_out),
    .wb_en_out    (wb_en_out),
    .wb_data_out  (wb_data_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".req"},     {31'd0, mem_req_out}, 32'd0);
    chk({tag, ".addr"},    mem_addr_out,         32'd0);
    chk({tag, ".we"},      {31'd0, mem_we_out},  32'd0);
    chk({tag, ".reg"},     {28'd0, reg_addr_out}, 32'd0);
    chk({tag, ".reg_we"},  {31'd0, reg_we_out},  32'd0);
    chk({tag, ".wb_en"},   {31'd0, wb_en_out},   32'd0);
    chk({tag, ".wb_data"}, wb_data_out,          32'd0);
    chk({tag, ".busy"},    {31'd0, busy_out},    32'd0);
    chk({tag, ".done"},    {31'd0, done_out},    32'd0);
  endtask

  // Called at the falling edge where start_in is to be presented (cycle 0). Returns at the
  // falling edge of the IDLE cycle following done_out.
  task automatic run(input string tag, input int n_beats, input logic exp_we,
                     input logic exp_wb, input logic [31:0] exp_wbd, input int exp_done,
                     input int ack_delay, input logic poke);
    int beat = 0;
    int stall = 0;
    int wb_seen = 0;
    int we_pulses = 0;
    int done_cyc = -1;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      // A second request while busy must not disturb the running transfer.
      if (poke && c == 2) begin
        start_in     = 1'b1;
        reg_list_in  = 16'hFFFF;
        base_addr_in = 32'hDEAD_0000;
      end else begin
        start_in = 1'b0;
      end
      if (mem_req_out) begin
        mem_ack_in = (stall >= ack_delay);
        #1;
        if (beat < n_beats) begin
          chk({tag, ".reg_addr"}, {28'd0, reg_addr_out}, {28'd0, e_reg[beat]});
          chk({tag, ".mem_addr"}, mem_addr_out, e_addr[beat]);
          chk({tag, ".mem_we"},   {31'd0, mem_we_out}, {31'd0, exp_we});
        end else begin
          chk({tag, ".extra_beat"}, 32'd1, 32'd0);
        end
        if (mem_ack_in) begin
          chk({tag, ".reg_we"}, {31'd0, reg_we_out}, {31'd0, load_in ^ poke ^ poke});
          if (reg_we_out) we_pulses++;
          beat++;
          stall = 0;
        end else begin
          chk({tag, ".reg_we_stall"}, {31'd0, reg_we_out}, 32'd0);
          stall++;
        end
      end else begin
        mem_ack_in = (ack_delay == 0);
        #1;
        chk({tag, ".reg_we_idle"}, {31'd0, reg_we_out}, 32'd0);
      end
      chk({tag, ".busy"}, {31'd0, busy_out}, 32'd1);
      if (wb_en_out) begin
        wb_seen++;
        chk({tag, ".wb_data"}, wb_data_out, exp_wbd);
        chk({tag, ".wb_cycle"}, c, exp_done - 1);
      end
      if (done_out) done_cyc = c;
      @(negedge clk_in);
    end
    start_in   = 1'b0;
    mem_ack_in = 1'b0;
    chk({tag, ".done_cycle"}, done_cyc, exp_done);
    chk({tag, ".beats"},      beat, n_beats);
    chk({tag, ".we_pulses"},  we_pulses, exp_we ? 0 : (load_in ? n_beats : 0));
    chk({tag, ".wb_count"},   wb_seen, {31'd0, exp_wb});
    #1;
    chk_zero({tag, ".after"});
  endtask

  initial begin
    reset_n_in   = 1'b0;
    start_in     = 1'b0;
    reg_list_in  = 16'd0;
    base_addr_in = 32'd0;
    mode_in      = 2'd0;
    load_in      = 1'b0;
    writeback_in = 1'b0;
    mem_ack_in   = 1'b1;
    #1;
    chk_zero("reset");
    @(negedge clk_in);
    @(negedge clk_in);
    chk_zero("reset_hold");

    // IA LDM with writeback, ack tied high; start presented with reset release.
    reset_n_in = 1'b1;
    reg_list_in = 16'h6721; base_addr_in = 32'h100; mode_in = 2'b00;
    load_in = 1'b1; writeback_in = 1'b1;
    e_reg[0] = 4'd0;  e_reg[1] = 4'd5;  e_reg[2] = 4'd8;  e_reg[3] = 4'd9;
    e_reg[4] = 4'd10; e_reg[5] = 4'd13; e_reg[6] = 4'd14;
    for (int k = 0; k < 7; k++) e_addr[k] = 32'h100 + 32'(4 * k);
    run("ia_ldm", 7, 1'b0, 1'b1, 32'h11C, 10, 0, 1'b0);

    // DB STM with writeback; stray start while busy.
    reg_list_in = 16'h0003; base_addr_in = 32'h100; mode_in = 2'b11;
    load_in = 1'b0; writeback_in = 1'b1;
    e_reg[0] = 4'd0; e_reg[1] = 4'd1;
    e_addr[0] = 32'hF8; e_addr[1] = 32'hFC;
    run("db_stm", 2, 1'b1, 1'b1, 32'hF8, 5, 0, 1'b1);

    // IB LDM, no writeback, three stall cycles before each ack.
    reg_list_in = 16'h8001; base_addr_in = 32'h200; mode_in = 2'b01;
    load_in = 1'b1; writeback_in = 1'b0;
    e_reg[0] = 4'd0; e_reg[1] = 4'd15;
    e_addr[0] = 32'h204; e_addr[1] = 32'h208;
    run("ib_stall", 2, 1'b0, 1'b0, 32'h0, 10, 3, 1'b0);

    // IA address wrap-around.
    reg_list_in = 16'h0003; base_addr_in = 32'hFFFF_FFFC; mode_in = 2'b00;
    load_in = 1'b0; writeback_in = 1'b1;
    e_reg[0] = 4'd0; e_reg[1] = 4'd1;
    e_addr[0] = 32'hFFFF_FFFC; e_addr[1] = 32'h0000_0000;
    run("ia_wrap", 2, 1'b1, 1'b1, 32'h4, 5, 0, 1'b0);

    // DA STM of r2,r4: N=2, start = 0x400-8+4.
    reg_list_in = 16'h0014; base_addr_in = 32'h400; mode_in = 2'b10;
    load_in = 1'b0; writeback_in = 1'b1;
    e_reg[0] = 4'd2; e_reg[1] = 4'd4;
    e_addr[0] = 32'h3FC; e_addr[1] = 32'h400;
    run("da_stm", 2, 1'b1, 1'b1, 32'h3F8, 5, 0, 1'b0);

    // Reset during the second beat of a 4-register LDM.
    reg_list_in = 16'h000F; base_addr_in = 32'h300; mode_in = 2'b00;
    load_in = 1'b1; writeback_in = 1'b1; mem_ack_in = 1'b1;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("abort.req_before", {31'd0, mem_req_out}, 32'd1);
    chk("abort.reg_before", {28'd0, reg_addr_out}, 32'd1);
    reset_n_in = 1'b0;
    #1;
    chk_zero("abort.now");
    @(negedge clk_in);
    chk_zero("abort.held");
    reset_n_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_in);
      chk("abort.no_done", {31'd0, done_out},  32'd0);
      chk("abort.no_wb",   {31'd0, wb_en_out}, 32'd0);
      chk("abort.idle",    {31'd0, busy_out},  32'd0);
    end

    // Empty list: straight to DONE, no beats and no writeback even with writeback set.
    reg_list_in = 16'h0000; base_addr_in = 32'h500; mode_in = 2'b00;
    load_in = 1'b1; writeback_in = 1'b1;
    run("empty", 0, 1'b0, 1'b0, 32'h0, 2, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
